// File: rtl/ex_flush_ctrl.sv
// -----------------------------------------------------------------------------
// ex_flush_ctrl
//
// Purpose:
//   Writeback-stage exception / ERET commit controller. When a valid WB
//   instruction carries an interrupt, an exception flag or an ERET, this block
//   raises the matching commit strobe to CP0 in the same cycle. It kills the
//   front of the pipeline and then holds a redirect request to the fetch stage
//   until fetch accepts it. While the redirect is outstanding, every new WB
//   event is ignored. An event that is still held when the block returns to
//   idle is taken in the first idle cycle.
//
// Parameters:
//   EX_ENTRY        exception handler entry PC
//
// Ports:
//   clk             single clock, rising edge
//   resetn          asynchronous active-low reset
//   wb_valid        WB stage holds a valid instruction
//   wb_pc           PC of the WB instruction
//   wb_bd           branch-delay-slot marker (consumed by CP0 directly)
//   wb_flags        {fetch_adel, ri, ov, sys, bp, data_adel, data_ades}
//   wb_data_addr    faulting load/store address
//   wb_eret         WB instruction is ERET
//   has_int         pending enabled interrupt
//   c0_epc          current EPC from CP0
//   fs_ready        fetch stage accepts a redirect this cycle
//   wb_ex           exception commit strobe (combinational, event cycle)
//   wb_excode       exception code for CP0
//   wb_badvaddr     bad virtual address for CP0
//   eret_flush      ERET commit strobe (combinational, event cycle)
//   flush_pipe      kill IF..MEM instructions
//   redirect_valid  redirect request to fetch
//   redirect_pc     redirect target, stable while redirect_valid is high
// -----------------------------------------------------------------------------
module ex_flush_ctrl #(
    parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic [6:0]  wb_flags,
    input  logic [31:0] wb_data_addr,
    input  logic        wb_eret,
    input  logic        has_int,
    input  logic [31:0] c0_epc,
    input  logic        fs_ready,
    output logic        wb_ex,
    output logic [4:0]  wb_excode,
    output logic [31:0] wb_badvaddr,
    output logic        eret_flush,
    output logic        flush_pipe,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // wb_flags bit positions
    localparam int F_FETCH_ADEL = 6;
    localparam int F_RI         = 5;
    localparam int F_OV         = 4;
    localparam int F_SYS        = 3;
    localparam int F_BP         = 2;
    localparam int F_DATA_ADEL  = 1;
    localparam int F_DATA_ADES  = 0;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] redirect_pc_q;

    logic        accept;      // block can take a new event this cycle
    logic        exc_any;     // interrupt or any exception flag present
    logic        ex_event;
    logic        eret_event;

    // Highest-priority exception code. Interrupt outranks every flag.
    function automatic logic [4:0] pick_excode(input logic       irq,
                                               input logic [6:0] flags);
        logic [4:0] code;
        code = EXC_INT;
        if (irq)                        code = EXC_INT;
        else if (flags[F_FETCH_ADEL])   code = EXC_ADEL;
        else if (flags[F_RI])           code = EXC_RI;
        else if (flags[F_OV])           code = EXC_OV;
        else if (flags[F_SYS])          code = EXC_SYS;
        else if (flags[F_BP])           code = EXC_BP;
        else if (flags[F_DATA_ADEL])    code = EXC_ADEL;
        else if (flags[F_DATA_ADES])    code = EXC_ADES;
        return code;
    endfunction

    // Bad address follows the same priority: the fetch PC for instruction
    // fetch faults, the data address for load/store faults, zero otherwise.
    function automatic logic [31:0] pick_badvaddr(input logic        irq,
                                                  input logic [6:0]  flags,
                                                  input logic [31:0] pc,
                                                  input logic [31:0] daddr);
        logic [31:0] addr;
        addr = 32'h0;
        if (irq)
            addr = 32'h0;
        else if (flags[F_FETCH_ADEL])
            addr = pc;
        else if (flags[F_RI] | flags[F_OV] | flags[F_SYS] | flags[F_BP])
            addr = 32'h0;
        else if (flags[F_DATA_ADEL] | flags[F_DATA_ADES])
            addr = daddr;
        return addr;
    endfunction

    // Event detection. resetn is folded in so that every commit output is
    // already low while reset is held, without waiting for a clock edge.
    always_comb begin
        accept     = resetn && (state == IDLE) && wb_valid;
        exc_any    = has_int || (|wb_flags);
        ex_event   = accept && exc_any;
        eret_event = accept && !exc_any && wb_eret;
    end

    // Commit strobes to CP0 and pipeline kill
    always_comb begin
        wb_ex          = ex_event;
        eret_flush     = eret_event;
        wb_excode      = 5'h0;
        wb_badvaddr    = 32'h0;
        if (ex_event) begin
            wb_excode   = pick_excode(has_int, wb_flags);
            wb_badvaddr = pick_badvaddr(has_int, wb_flags, wb_pc, wb_data_addr);
        end
        redirect_valid = resetn && (state == REDIRECT);
        flush_pipe     = ex_event || eret_event || redirect_valid;
        redirect_pc    = redirect_pc_q;
    end

    // Redirect FSM: target is captured on the event edge and held until the
    // fetch handshake completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            redirect_pc_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_event) begin
                        state         <= REDIRECT;
                        redirect_pc_q <= EX_ENTRY;
                    end else if (eret_event) begin
                        state         <= REDIRECT;
                        redirect_pc_q <= c0_epc;
                    end
                end
                REDIRECT: begin
                    if (fs_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // wb_bd is consumed by CP0 straight from the WB stage; it is not used here.
    logic unused_bd;
    assign unused_bd = wb_bd;

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ex_flush_ctrl
//
// Self-checking bench for ex_flush_ctrl. A behavioural reference model tracks
// "redirect outstanding" and its target. It computes the expected outputs
// from the priority table. Directed scenarios come first, followed by a
// randomized run.
// -----------------------------------------------------------------------------
module tb_ex_flush_ctrl;

    localparam logic [31:0] EX_ENTRY = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_bd;
    logic [6:0]  wb_flags;
    logic [31:0] wb_data_addr;
    logic        wb_eret;
    logic        has_int;
    logic [31:0] c0_epc;
    logic        fs_ready;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic [31:0] wb_badvaddr;
    logic        eret_flush;
    logic        flush_pipe;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ex_flush_ctrl #(.EX_ENTRY(EX_ENTRY)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_bd          (wb_bd),
        .wb_flags       (wb_flags),
        .wb_data_addr   (wb_data_addr),
        .wb_eret        (wb_eret),
        .has_int        (has_int),
        .c0_epc         (c0_epc),
        .fs_ready       (fs_ready),
        .wb_ex          (wb_ex),
        .wb_excode      (wb_excode),
        .wb_badvaddr    (wb_badvaddr),
        .eret_flush     (eret_flush),
        .flush_pipe     (flush_pipe),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Exception code per wb_flags bit index (bit 0 = data_ades .. bit 6 = fetch_adel)
    int codes [0:6] = '{5, 4, 9, 8, 12, 10, 4};

    // Reference model state
    bit          m_busy;
    logic [31:0] m_pc;

    // Expected outputs for the current cycle
    logic        e_ex, e_eret, e_flush, e_rv;
    logic [4:0]  e_code;
    logic [31:0] e_bad, e_rpc;

    // Last sampled DUT outputs, for directed constant checks
    logic        o_ex, o_eret, o_flush, o_rv;
    logic [4:0]  o_code;
    logic [31:0] o_bad, o_rpc;
    int          rv_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit found;
        e_ex = 0; e_eret = 0; e_code = '0; e_bad = '0;
        e_rv = 0; e_rpc = '0; e_flush = 0;
        if (resetn) begin
            e_rv    = m_busy;
            e_rpc   = m_pc;
            e_flush = m_busy;
            if (!m_busy && wb_valid) begin
                if (has_int) begin
                    e_ex = 1;
                end else begin
                    found = 0;
                    for (int b = 6; b >= 0; b--) begin
                        if (!found && wb_flags[b]) begin
                            found  = 1;
                            e_ex   = 1;
                            e_code = 5'(codes[b]);
                            e_bad  = (b == 6) ? wb_pc : (b <= 1) ? wb_data_addr : 32'h0;
                        end
                    end
                    if (!found && wb_eret) e_eret = 1;
                end
                e_flush = e_ex | e_eret;
            end
        end
    endtask

    task automatic model_advance();
        if (!resetn) begin
            m_busy = 0;
            m_pc   = '0;
        end else if (e_ex) begin
            m_busy = 1;
            m_pc   = EX_ENTRY;
        end else if (e_eret) begin
            m_busy = 1;
            m_pc   = c0_epc;
        end else if (m_busy && fs_ready) begin
            m_busy = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wb_ex"},          32'(wb_ex),          32'(e_ex));
        chk({tag, ".wb_excode"},      32'(wb_excode),      32'(e_code));
        chk({tag, ".wb_badvaddr"},    wb_badvaddr,         e_bad);
        chk({tag, ".eret_flush"},     32'(eret_flush),     32'(e_eret));
        chk({tag, ".flush_pipe"},     32'(flush_pipe),     32'(e_flush));
        chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(e_rv));
        chk({tag, ".redirect_pc"},    redirect_pc,         e_rpc);
    endtask

    // One clock cycle: sample at the falling edge, check, advance the model,
    // then let the rising edge happen. Inputs are changed 1ns after it.
    task automatic cycle(input string tag);
        @(negedge clk);
        model_eval();
        check_all(tag);
        o_ex = wb_ex; o_eret = eret_flush; o_flush = flush_pipe; o_rv = redirect_valid;
        o_code = wb_excode; o_bad = wb_badvaddr; o_rpc = redirect_pc;
        if (redirect_valid) rv_seen++;
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_flags = '0; wb_eret = 0; has_int = 0;
        wb_pc = '0; wb_data_addr = '0; c0_epc = '0; fs_ready = 1; wb_bd = 0;
    endtask

    initial begin
        resetn = 0;
        idle_inputs();
        m_busy = 0;
        m_pc   = '0;
        rv_seen = 0;

        // Reset state, even with an event presented
        #2;
        wb_valid = 1; has_int = 1;
        cycle("reset0");
        cycle("reset1");
        chk("reset_rv", 32'(o_rv), 32'h0);
        idle_inputs();
        resetn = 1;

        // Fetch AdEL + RI, first cycle after reset
        wb_valid = 1; wb_flags = 7'b1100000; wb_pc = 32'h80001004; fs_ready = 1;
        cycle("d39_ev");
        chk("d39_ex",   32'(o_ex),   32'h1);
        chk("d39_code", 32'(o_code), 32'h04);
        chk("d39_bad",  o_bad,       32'h80001004);
        idle_inputs();
        cycle("d39_rd");
        chk("d39_rv",  32'(o_rv), 32'h1);
        chk("d39_rpc", o_rpc,     32'hbfc00380);
        cycle("d39_idle");

        // ERET with fetch stalled for three cycles
        wb_valid = 1; wb_eret = 1; c0_epc = 32'h80002000; fs_ready = 0;
        rv_seen = 0;
        cycle("d40_ev");
        chk("d40_eret", 32'(o_eret), 32'h1);
        chk("d40_ex",   32'(o_ex),   32'h0);
        idle_inputs();
        fs_ready = 0;
        cycle("d40_w1");
        chk("d40_eret_pulse", 32'(o_eret), 32'h0);
        cycle("d40_w2");
        cycle("d40_w3");
        fs_ready = 1;
        cycle("d40_w4");
        chk("d40_rpc", o_rpc, 32'h80002000);
        cycle("d40_idle");
        chk("d40_rv_len", 32'(rv_seen), 32'd4);

        // Interrupt together with ERET: interrupt wins
        wb_valid = 1; has_int = 1; wb_eret = 1; wb_flags = '0; c0_epc = 32'h12345678;
        cycle("d41_ev");
        chk("d41_ex",   32'(o_ex),   32'h1);
        chk("d41_code", 32'(o_code), 32'h00);
        chk("d41_eret", 32'(o_eret), 32'h0);
        idle_inputs();
        cycle("d41_rd");
        chk("d41_rpc", o_rpc, EX_ENTRY);

        // Event held during REDIRECT is taken right after return to IDLE
        wb_valid = 1; wb_flags = 7'b0001000; fs_ready = 0;
        cycle("d42_ev");
        wb_flags = 7'b0010000;
        cycle("d42_blk1");
        chk("d42_blk1_ex", 32'(o_ex), 32'h0);
        fs_ready = 1;
        cycle("d42_blk2");
        chk("d42_blk2_ex", 32'(o_ex), 32'h0);
        cycle("d42_take");
        chk("d42_take_ex",   32'(o_ex),   32'h1);
        chk("d42_take_code", 32'(o_code), 32'h0c);
        idle_inputs();
        fs_ready = 0;
        cycle("d43_rd");

        // Reset asserted mid-REDIRECT clears outputs without a clock edge
        #2;
        resetn = 0;
        #1;
        chk("d43_rv",    32'(redirect_valid), 32'h0);
        chk("d43_flush", 32'(flush_pipe),     32'h0);
        chk("d43_rpc",   redirect_pc,         32'h0);
        m_busy = 0;
        m_pc   = '0;
        cycle("d43_inrst");
        resetn = 1;
        fs_ready = 1;
        cycle("d43_post");
        chk("d43_post_rv", 32'(o_rv), 32'h0);

        // Data AdES
        wb_valid = 1; wb_flags = 7'b0000001; wb_data_addr = 32'h00000003; wb_pc = 32'h80000040;
        cycle("d44_ev");
        chk("d44_code", 32'(o_code), 32'h05);
        chk("d44_bad",  o_bad,       32'h00000003);
        idle_inputs();
        cycle("d44_rd");

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            wb_valid     = ($urandom_range(0, 3) != 0);
            wb_flags     = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h0;
            wb_eret      = ($urandom_range(0, 3) == 0);
            has_int      = ($urandom_range(0, 7) == 0);
            wb_pc        = $urandom;
            wb_data_addr = $urandom;
            c0_epc       = $urandom;
            fs_ready     = ($urandom_range(0, 1) == 1);
            wb_bd        = 1'($urandom);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
